apple_tracker: RTL

//  Downstream consumer of the apple-coordinate generator. Holds the current

---
 rtl/snake_pkg.sv | 23 ++
 rtl/bcd_counter.sv | 38 +++
 rtl/apple_tracker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game types: cell colours, grid geometry, coordinates and
// the apple tracker state encoding.
package snake_pkg;

    typedef enum logic [1:0] {
        CELL_OFF,
        CELL_RED,
        CELL_GRN,
        CELL_YEL
    } cellStateColor;

    localparam int GRID = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        SETTLE,
        PLACE,
        ACTIVE,
        FULL
    } apple_state_t;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with ripple carry; all-9s wraps to zero.
// Shared by the score and the snake length display.
module bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] value_n;
    logic                carry;

    always_comb begin
        value_n = value;
        carry   = inc;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (value[4*d +: 4] == 4'd9) begin
                    value_n[4*d +: 4] = 4'd0;
                end else begin
                    value_n[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else begin
            value <= value_n;
        end
    end

endmodule

// File: rtl/apple_tracker.sv
// Holds the apple position, qualifies generator candidates against the
// playfield, detects eats (grow pulse + BCD score) and drives the overlay.
module apple_tracker
    import snake_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 8,
    parameter int SCORE_DIGITS  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           game_active,
    input  logic                           tick,
    input  coord_t                         head_x,
    input  coord_t                         head_y,
    input  coord_t                         cand_x,
    input  coord_t                         cand_y,
    input  logic [GRID-1:0][GRID-1:0]      RedPixels,
    input  logic [GRID-1:0][GRID-1:0]      GrnPixels,
    output coord_t                         apple_x,
    output coord_t                         apple_y,
    output logic                           apple_valid,
    output logic [GRID-1:0][GRID-1:0]      ApplePixels,
    output logic                           grow,
    output logic [4*SCORE_DIGITS-1:0]      score,
    output logic                           board_full,
    output apple_state_t                   dbg_state,
    output logic [7:0]                     dbg_retry
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [7:0] RETRY_LAST  = 8'(MAX_RETRY - 1);

    apple_state_t              state, state_n;
    logic [7:0]                settle_cnt, settle_n;
    logic [7:0]                retry, retry_n;
    coord_t                    apple_x_n, apple_y_n;
    logic                      apple_valid_n, board_full_n, grow_n;
    logic                      score_inc, cand_free, eat;
    logic [GRID-1:0][GRID-1:0] pixels_n;

    assign dbg_state = state;
    assign dbg_retry = retry;

    always_comb begin
        cand_free = ~RedPixels[cand_x][cand_y] & ~GrnPixels[cand_x][cand_y];
        eat = tick & game_active & apple_valid &
              (head_x == apple_x) & (head_y == apple_y);

        state_n       = state;
        settle_n      = settle_cnt;
        retry_n       = retry;
        apple_x_n     = apple_x;
        apple_y_n     = apple_y;
        apple_valid_n = apple_valid;
        board_full_n  = board_full;
        grow_n        = 1'b0;
        score_inc     = 1'b0;

        // With the game paused nothing moves; grow is the only output forced low.
        if (game_active) begin
            case (state)
                SETTLE: begin
                    if (settle_cnt <= 8'd1) begin
                        settle_n = 8'd0;
                        state_n  = PLACE;
                    end else begin
                        settle_n = settle_cnt - 8'd1;
                    end
                end
                PLACE: begin
                    if (cand_free) begin
                        apple_x_n     = cand_x;
                        apple_y_n     = cand_y;
                        apple_valid_n = 1'b1;
                        retry_n       = 8'd0;
                        state_n       = ACTIVE;
                    end else begin
                        retry_n = retry + 8'd1;
                        if (retry == RETRY_LAST) begin
                            board_full_n = 1'b1;
                            state_n      = FULL;
                        end
                    end
                end
                ACTIVE: begin
                    if (eat) begin
                        grow_n        = 1'b1;
                        score_inc     = 1'b1;
                        apple_valid_n = 1'b0;
                        settle_n      = SETTLE_INIT;
                        state_n       = SETTLE;
                    end
                end
                FULL: begin
                    apple_valid_n = 1'b0;
                end
                default: state_n = SETTLE;
            endcase
        end

        // Overlay decoded from next-state values so it lines up with apple_valid.
        pixels_n = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                pixels_n[r][c] = apple_valid_n & (apple_x_n == 4'(r)) & (apple_y_n == 4'(c));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SETTLE;
            settle_cnt  <= SETTLE_INIT;
            retry       <= 8'd0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            board_full  <= 1'b0;
            grow        <= 1'b0;
            ApplePixels <= '0;
        end else begin
            state       <= state_n;
            settle_cnt  <= settle_n;
            retry       <= retry_n;
            apple_x     <= apple_x_n;
            apple_y     <= apple_y_n;
            apple_valid <= apple_valid_n;
            board_full  <= board_full_n;
            grow        <= grow_n;
            ApplePixels <= pixels_n;
        end
    end

    bcd_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (score_inc),
        .value (score)
    );

endmodule
